// File: rtl/eager_fork_data_pkg.sv
// Shared defaults for the eager fork.
// Latency: none, this file holds constants only.
// Backpressure: not applicable.
package eager_fork_data_pkg;

  // Default number of consumer branches.
  localparam int DEFAULT_OUTPUTS   = 2;
  // Default token width in bits.
  localparam int DEFAULT_DATA_TYPE = 32;

endpackage

// File: rtl/eager_fork_data_register_block.sv
// Per-branch state of the eager fork: remembers whether this branch already took the token.
// Latency: 0 cycles, outs_valid and done are combinational from inputs and the sent bit.
// Backpressure: a stalled branch keeps outs_valid high until it accepts; a served branch goes quiet.
module eager_fork_register_block (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  input  logic outs_ready,
  input  logic all_done,
  output logic outs_valid,
  output logic done
);
  import eager_fork_data_pkg::*;

  logic sent_q;
  logic sent_d;

  // Offer the token until this branch takes it; retire clears the bit for the next token.
  always_comb begin
    outs_valid = ins_valid & ~sent_q;
    done       = sent_q | outs_ready;
    sent_d     = sent_q | (outs_valid & outs_ready);
    if (ins_valid && all_done) begin
      sent_d = 1'b0;
    end
  end

  // Sent bit, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sent_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule

// File: rtl/eager_fork_data.sv
// Eager fork: broadcasts one elastic input token to OUTPUTS consumers, each firing independently.
// Latency: 0 cycles, data and valid/ready are combinational, no buffering stage.
// Backpressure: ins_ready rises only once every branch has taken or is taking the token.
module eager_fork_data
  import eager_fork_data_pkg::*;
#(
  parameter int OUTPUTS   = DEFAULT_OUTPUTS,
  parameter int DATA_TYPE = DEFAULT_DATA_TYPE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_TYPE-1:0]           ins,
  input  logic                           ins_valid,
  output logic                           ins_ready,
  output logic [OUTPUTS*DATA_TYPE-1:0]   outs,
  output logic [OUTPUTS-1:0]             outs_valid,
  input  logic [OUTPUTS-1:0]             outs_ready
);

  logic [OUTPUTS-1:0] done;
  logic               all_done;

  // The token retires when every branch is done; this does not look at ins_valid.
  assign all_done  = &done;
  assign ins_ready = all_done;

  for (genvar g = 0; g < OUTPUTS; g++) begin : g_branch
    // Every branch carries the input data directly; there is no data register.
    assign outs[g*DATA_TYPE +: DATA_TYPE] = ins;

    eager_fork_register_block u_reg (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .outs_ready (outs_ready[g]),
      .all_done   (all_done),
      .outs_valid (outs_valid[g]),
      .done       (done[g])
    );
  end

endmodule

// File: tb/tb_eager_fork_data.sv
// Bench for the eager fork: directed vectors on a 3-branch instance, random stress on a 4-branch one.
// Latency: not applicable.
// Backpressure: producer holds each token until it retires; consumers toggle ready freely.
module tb_eager_fork_data;

  logic        clk = 1'b0;
  logic        rst;

  // 3-branch instance
  logic [7:0]  ins3;
  logic        iv3;
  logic        ir3;
  logic [23:0] outs3;
  logic [2:0]  ov3;
  logic [2:0]  or3;

  // 4-branch instance
  logic [7:0]  ins4;
  logic        iv4;
  logic        ir4;
  logic [31:0] outs4;
  logic [3:0]  ov4;
  logic [3:0]  or4;

  int nvec = 0;
  int nerr = 0;
  logic chk_en = 1'b0;

  // Token-count model of the 3-branch fork: dlv[i] tokens delivered to branch i, ret tokens retired.
  int dlv [3];
  int ret = 0;

  // Scoreboards for the 4-branch stress run.
  logic [7:0] expq [$];
  logic [7:0] gotq [4][$];

  always #5 clk = ~clk;

  eager_fork_data #(.OUTPUTS(3), .DATA_TYPE(8)) dut3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(iv3), .ins_ready(ir3),
    .outs(outs3), .outs_valid(ov3), .outs_ready(or3)
  );

  eager_fork_data #(.OUTPUTS(4), .DATA_TYPE(8)) dut4 (
    .clk(clk), .rst(rst), .ins(ins4), .ins_valid(iv4), .ins_ready(ir4),
    .outs(outs4), .outs_valid(ov4), .outs_ready(or4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model and scoreboards.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] ev;
      logic       er;
      er = 1'b1;
      for (int i = 0; i < 3; i++) begin
        ev[i] = iv3 && (dlv[i] == ret);
        if (!(dlv[i] > ret || or3[i])) er = 1'b0;
      end
      chk("model_valid", {29'd0, ov3}, {29'd0, ev});
      chk("model_ready", {31'd0, ir3}, {31'd0, er});
      chk("data3", {8'd0, outs3}, {8'd0, ins3, ins3, ins3});
      chk("data4", outs4, {ins4, ins4, ins4, ins4});

      if (!rst) begin
        for (int i = 0; i < 3; i++) dlv[i] = ret;
      end else if (iv3 && er) begin
        ret++;
        for (int i = 0; i < 3; i++) dlv[i] = ret;
      end else begin
        for (int i = 0; i < 3; i++) if (ev[i] && or3[i]) dlv[i]++;
      end

      if (rst) begin
        for (int b = 0; b < 4; b++) if (ov4[b] && or4[b]) gotq[b].push_back(ins4);
        if (iv4 && ir4) expq.push_back(ins4);
      end
    end
  end

  // One directed cycle on the 3-branch instance with literal expectations.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic [2:0] rdy,
                     input logic [2:0] exp_ov, input logic exp_ir, input string nm);
    rst = r; iv3 = v; ins3 = d; or3 = rdy;
    @(negedge clk);
    chk({nm, "_ov"}, {29'd0, ov3}, {29'd0, exp_ov});
    chk({nm, "_ir"}, {31'd0, ir3}, {31'd0, exp_ir});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic hs;
    int   issued;
    int   cycles;
    int   n;

    for (int i = 0; i < 3; i++) dlv[i] = 0;
    rst = 1'b0; iv3 = 1'b1; ins3 = 8'h55; or3 = 3'b000;
    iv4 = 1'b0; ins4 = 8'h00; or4 = 4'b0000;
    @(posedge clk);
    chk_en = 1'b1;
    #1;

    // Reset held with ins_valid=1, then first released cycle.
    cyc(1'b0, 1'b1, 8'h55, 3'b000, 3'b111, 1'b0, "rst_hold");
    cyc(1'b1, 1'b1, 8'h55, 3'b000, 3'b111, 1'b0, "rst_rel");
    cyc(1'b1, 1'b1, 8'h55, 3'b111, 3'b111, 1'b1, "rst_flush");

    // All branches ready together.
    cyc(1'b1, 1'b1, 8'hA5, 3'b111, 3'b111, 1'b1, "all_rdy");

    // Staggered accept.
    cyc(1'b1, 1'b1, 8'h3C, 3'b001, 3'b111, 1'b0, "stag0");
    cyc(1'b1, 1'b1, 8'h3C, 3'b010, 3'b110, 1'b0, "stag1");
    cyc(1'b1, 1'b1, 8'h3C, 3'b100, 3'b100, 1'b1, "stag2");

    // Back-pressure hold, then release.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 8'h11, 3'b000, 3'b111, 1'b0, "bp_hold");
    cyc(1'b1, 1'b1, 8'h11, 3'b111, 3'b111, 1'b1, "bp_rel");

    // Valid dropped mid-token: sent holds and the next valid completes the same token.
    cyc(1'b1, 1'b1, 8'h22, 3'b010, 3'b111, 1'b0, "drop0");
    cyc(1'b1, 1'b0, 8'h22, 3'b000, 3'b000, 1'b0, "drop1");
    cyc(1'b1, 1'b1, 8'h23, 3'b101, 3'b101, 1'b1, "drop2");

    // Reset mid-token re-offers the token to every branch.
    cyc(1'b1, 1'b1, 8'h77, 3'b001, 3'b111, 1'b0, "mid0");
    cyc(1'b1, 1'b1, 8'h77, 3'b000, 3'b110, 1'b0, "mid1");
    cyc(1'b0, 1'b1, 8'h77, 3'b000, 3'b110, 1'b0, "mid_rst");
    cyc(1'b1, 1'b1, 8'h77, 3'b000, 3'b111, 1'b0, "mid_reoffer");
    cyc(1'b1, 1'b1, 8'h77, 3'b111, 3'b111, 1'b1, "mid_done");
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, "idle");

    // Random stress on the 4-branch instance.
    hs = 1'b0; issued = 0; cycles = 0;
    while (expq.size() < 1000 && cycles < 20000) begin
      if (hs) iv4 = 1'b0;
      if (!iv4 && issued < 1000 && $urandom_range(0, 3) != 0) begin
        iv4 = 1'b1;
        ins4 = 8'($urandom);
        issued++;
      end
      or4 = 4'($urandom_range(0, 15));
      @(negedge clk);
      hs = iv4 & ir4;
      @(posedge clk);
      #1;
      cycles++;
    end
    iv4 = 1'b0; or4 = 4'b0000;
    @(negedge clk);
    @(posedge clk);
    #1;

    chk("stress_tokens", expq.size(), 32'd1000);
    for (int b = 0; b < 4; b++) begin
      chk("sb_len", gotq[b].size(), expq.size());
      n = (gotq[b].size() < expq.size()) ? gotq[b].size() : expq.size();
      for (int k = 0; k < n; k++) chk("sb_dat", {24'd0, gotq[b][k]}, {24'd0, expq[k]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
